// File: rtl/shift_arb_pkg.sv
// Shared widths, latency default and tracker entry type for the shift arbiter.
// Latency and backpressure: not applicable (types only).
package shift_arb_pkg;

   localparam int DATA_W  = 32;
   localparam int AMT_W   = 5;
   localparam int LAT_DEF = 5;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [AMT_W-1:0]  amt_t;

   typedef enum logic {
      OWN_R0 = 1'b0,
      OWN_R1 = 1'b1
   } owner_e;

   typedef struct packed {
      logic   vld;
      owner_e owner;
   } tag_t;

   function automatic owner_e other_owner(input owner_e o);
      return (o == OWN_R0) ? OWN_R1 : OWN_R0;
   endfunction

endpackage

// File: rtl/shift_arb_if.sv
// Requester, shifter and result signals of the shift arbiter.
// master = requesters plus external shifter, slave = the arbiter.
interface shift_arb_if;
   import shift_arb_pkg::*;

   logic  r0_vld;
   data_t r0_data;
   amt_t  r0_amt;
   logic  r0_rdy;

   logic  r1_vld;
   data_t r1_data;
   amt_t  r1_amt;
   logic  r1_rdy;

   logic  sh_vld;
   data_t sh_in;
   amt_t  sh_amt;
   data_t sh_res;

   logic  r0_done;
   logic  r1_done;
   data_t res;

   modport master (
      output r0_vld, r0_data, r0_amt,
      output r1_vld, r1_data, r1_amt,
      output sh_res,
      input  r0_rdy, r1_rdy,
      input  sh_vld, sh_in, sh_amt,
      input  r0_done, r1_done, res
   );

   modport slave (
      input  r0_vld, r0_data, r0_amt,
      input  r1_vld, r1_data, r1_amt,
      input  sh_res,
      output r0_rdy, r1_rdy,
      output sh_vld, sh_in, sh_amt,
      output r0_done, r1_done, res
   );

endinterface

// File: rtl/shift_arb_tag_pipe.sv
// Tag tracker: LAT-deep {vld, owner} delay line, entry emerges LAT cycles after load.
// No backpressure: advances every cycle; synchronous reset clears all entries.
module tag_pipe
   import shift_arb_pkg::*;
#(
   parameter int LAT = LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  tag_t in_tag,
   output tag_t out_tag
);

   tag_t [LAT-1:0] pipe_q;
   tag_t [LAT-1:0] pipe_d;

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = in_tag;
      for (int i = 1; i < LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign out_tag = pipe_q[LAT-1];

endmodule

// File: rtl/shift_arb.sv
// Round-robin arbiter sharing one LAT-cycle pipelined shifter between two requesters.
// Issue 1 cycle after grant, result LAT cycles after issue; no result backpressure.
module shift_arb
   import shift_arb_pkg::*;
#(
   parameter int LAT = LAT_DEF
) (
   input  logic      clk,
   input  logic      rst,
   shift_arb_if.slave bus
);

   owner_e rr_q,       rr_d;
   logic   sh_vld_q,   sh_vld_d;
   data_t  sh_in_q,    sh_in_d;
   amt_t   sh_amt_q,   sh_amt_d;
   owner_e own_q,      own_d;
   data_t  res_q,      res_d;

   logic   gnt0;
   logic   gnt1;
   logic   done0;
   logic   done1;
   tag_t   issue_tag;
   tag_t   due_tag;

   // Grant is purely combinational so a lone requester is accepted in the same cycle.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (bus.r0_vld && (!bus.r1_vld || rr_q == OWN_R0)) begin
            gnt0 = 1'b1;
         end else if (bus.r1_vld) begin
            gnt1 = 1'b1;
         end
      end
   end

   always_comb begin
      rr_d     = rr_q;
      sh_vld_d = gnt0 | gnt1;
      sh_in_d  = sh_in_q;
      sh_amt_d = sh_amt_q;
      own_d    = own_q;
      if (gnt0) begin
         rr_d     = other_owner(OWN_R0);
         sh_in_d  = bus.r0_data;
         sh_amt_d = bus.r0_amt;
         own_d    = OWN_R0;
      end else if (gnt1) begin
         rr_d     = other_owner(OWN_R1);
         sh_in_d  = bus.r1_data;
         sh_amt_d = bus.r1_amt;
         own_d    = OWN_R1;
      end
   end

   always_comb begin
      issue_tag.vld   = sh_vld_q;
      issue_tag.owner = own_q;
   end

   tag_pipe #(
      .LAT (LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_tag  (issue_tag),
      .out_tag (due_tag)
   );

   // res passes sh_res through on a due cycle and otherwise replays the last result.
   always_comb begin
      res_d = res_q;
      if (due_tag.vld) begin
         res_d = bus.sh_res;
      end
      done0 = !rst && due_tag.vld && (due_tag.owner == OWN_R0);
      done1 = !rst && due_tag.vld && (due_tag.owner == OWN_R1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q     <= OWN_R0;
         sh_vld_q <= 1'b0;
         sh_in_q  <= '0;
         sh_amt_q <= '0;
         own_q    <= OWN_R0;
         res_q    <= '0;
      end else begin
         rr_q     <= rr_d;
         sh_vld_q <= sh_vld_d;
         sh_in_q  <= sh_in_d;
         sh_amt_q <= sh_amt_d;
         own_q    <= own_d;
         res_q    <= res_d;
      end
   end

   // Outputs are forced low during reset, including the cycle rst first rises.
   assign bus.r0_rdy  = gnt0;
   assign bus.r1_rdy  = gnt1;
   assign bus.sh_vld  = sh_vld_q & ~rst;
   assign bus.sh_in   = rst ? '0 : sh_in_q;
   assign bus.sh_amt  = rst ? '0 : sh_amt_q;
   assign bus.r0_done = done0;
   assign bus.r1_done = done1;
   assign bus.res     = rst ? '0 : res_d;

   a_one_grant : assert property (@(posedge clk) !(gnt0 && gnt1));
   a_one_done  : assert property (@(posedge clk) !(done0 && done1));

endmodule

// File: tb/tb_shift_arb.sv
// Bench for shift_arb: grant table plus hand-written sequences, scoreboarded issue/result checks.
module tb_shift_arb;
   import shift_arb_pkg::*;

   localparam int LAT = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   shift_arb_if bus ();

   shift_arb #(.LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // External shifter: LAT-cycle delay of sh_in << sh_amt, junk when nothing issued.
   logic [31:0] shp [LAT] = '{default: 32'h0};
   always @(posedge clk) begin
      shp[0] <= bus.sh_vld ? (bus.sh_in << bus.sh_amt) : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) shp[i] <= shp[i-1];
   end
   assign bus.sh_res = shp[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          due;
      logic [31:0] d;
      logic [4:0]  a;
   } iss_t;

   typedef struct {
      int          due;
      logic        own;
      logic [31:0] v;
   } rsl_t;

   iss_t        iq [$];
   rsl_t        rq [$];
   logic [31:0] last_res = 32'h0;

   typedef struct {
      logic v0;
      logic v1;
      logic e0;
      logic e1;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input logic own, input logic [31:0] d, input logic [4:0] a);
      iss_t i_e;
      rsl_t r_e;
      i_e.due = cyc + 1;
      i_e.d   = d;
      i_e.a   = a;
      r_e.due = cyc + 1 + LAT;
      r_e.own = own;
      r_e.v   = d << a;
      iq.push_back(i_e);
      rq.push_back(r_e);
   endtask

   task automatic drive(input logic r, input logic v0, input logic v1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic e0, input logic e1);
      @(posedge clk);
      #1;
      rst         = r;
      bus.r0_vld  = v0;
      bus.r0_data = d0;
      bus.r0_amt  = a0;
      bus.r1_vld  = v1;
      bus.r1_data = d1;
      bus.r1_amt  = a1;
      @(negedge clk);
      chk("r0_rdy", bus.r0_rdy, e0);
      chk("r1_rdy", bus.r1_rdy, e1);
      if (e0) push(1'b0, d0, a0);
      if (e1) push(1'b1, d1, a1);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   // Monitor: every cycle, compare issue and result ports against the queue heads.
   initial begin
      logic iexp;
      logic rexp;
      logic rown;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_sh_vld", bus.sh_vld, 0);
            chk("rst_sh_in", bus.sh_in, 0);
            chk("rst_sh_amt", bus.sh_amt, 0);
            chk("rst_done", {bus.r0_done, bus.r1_done}, 0);
            chk("rst_res", bus.res, 0);
            iq.delete();
            rq.delete();
            last_res = 32'h0;
         end else begin
            iexp = (iq.size() > 0) && (iq[0].due == cyc);
            chk("sh_vld", bus.sh_vld, iexp);
            if (iexp) begin
               chk("sh_in", bus.sh_in, iq[0].d);
               chk("sh_amt", bus.sh_amt, iq[0].a);
               void'(iq.pop_front());
            end
            rexp = (rq.size() > 0) && (rq[0].due == cyc);
            rown = rexp ? rq[0].own : 1'b0;
            chk("r0_done", bus.r0_done, rexp && !rown);
            chk("r1_done", bus.r1_done, rexp && rown);
            if (rexp) begin
               chk("res", bus.res, rq[0].v);
               last_res = rq[0].v;
               void'(rq.pop_front());
            end else begin
               chk("res_hold", bus.res, last_res);
            end
         end
      end
   end

   initial begin
      //               v0    v1    e0    e1
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0};

      bus.r0_vld  = 1'b0;
      bus.r0_data = 32'h0;
      bus.r0_amt  = 5'd0;
      bus.r1_vld  = 1'b0;
      bus.r1_data = 32'h0;
      bus.r1_amt  = 5'd0;

      // Reset with both requesters valid: nothing may be granted.
      drive(1'b1, 1'b1, 1'b1, 32'h1111, 32'h2222, 5'd1, 5'd2, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 32'h1111, 32'h2222, 5'd1, 5'd2, 1'b0, 1'b0);

      // Single request in the first cycle out of reset, then r1 lands on r0's delivery cycle.
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h0, 5'd4, 5'd0, 1'b1, 1'b0);
      idle(LAT);
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0303, 5'd0, 5'd8, 1'b0, 1'b1);
      idle(LAT + 2);

      // Grant table from a fresh reset so rr starts at requester 0.
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) begin
         drive(1'b0, tbl[i].v0, tbl[i].v1,
               32'h0000_1000 + i, 32'hA5A5_0000 + i,
               5'(i), 5'(31 - i), tbl[i].e0, tbl[i].e1);
      end
      idle(LAT + 2);

      // Back-to-back on r1 with boundary shift amounts.
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0,  1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd1,  1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd31, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd2,  1'b0, 1'b1);
      idle(LAT + 2);

      // Reset mid-flight: three issues, reset two cycles after the last grant.
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0011, 32'h0, 5'd1, 5'd0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0022, 32'h0, 5'd2, 5'd0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0033, 32'h0, 5'd3, 5'd0, 1'b1, 1'b0);
      idle(1);
      drive(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 5'd4, 5'd0, 1'b0, 1'b0);
      idle(LAT + 3);
      drive(1'b0, 1'b1, 1'b0, 32'h00C0_FFEE, 32'h0, 5'd3, 5'd0, 1'b1, 1'b0);
      idle(LAT + 2);

      chk("drain_issue_q", iq.size(), 0);
      chk("drain_result_q", rq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
